serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 172 +++++++++++++++++
 tb/tb_serial_addsub.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle over N = WIDTH/CHUNK cycles,
// with signed-overflow detection and optional saturation to the signed range.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ctrl,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ctrl_q, ctrl_d;
  logic             sat_q, sat_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] s_sat;
  logic [WIDTH-1:0] s_final;
  logic             ovf_raw;

  // Start is only honoured outside BUSY, which also covers back-to-back from DONE.
  assign accept     = start && (state_q != StBusy);
  assign last_chunk = (idx_q == IdxW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StBusy;
      StBusy:  if (last_chunk) state_d = StDone;
      StDone:  state_d = start ? StBusy : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StBusy:  busy = 1'b1;
      StDone:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Per-cycle chunk adder and final-result shaping
  always_comb begin
    a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk   = b_q[idx_q*CHUNK +: CHUNK] ^ {CHUNK{ctrl_q}};
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    s_raw = s_q;
    s_raw[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];

    // Same-sign operands producing an opposite-sign result is exactly Cin(MSB) ^ Cout(MSB).
    ovf_raw = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ ctrl_q)) && (s_raw[WIDTH-1] != a_q[WIDTH-1]);

    s_sat   = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    s_final = (sat_q && ovf_raw) ? s_sat : s_raw;
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    sat_d   = sat_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    if (accept) begin
      a_d     = A;
      b_d     = B;
      ctrl_d  = ctrl;
      sat_d   = sat;
      idx_d   = '0;
      carry_d = ctrl;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      zero_d  = 1'b0;
    end else if (state_q == StBusy) begin
      carry_d = chunk_sum[CHUNK];
      idx_d   = idx_q + 1'b1;
      if (last_chunk) begin
        s_d    = s_final;
        cout_d = chunk_sum[CHUNK];
        ovf_d  = ovf_raw;
        zero_d = (s_final == '0);
      end else begin
        s_d = s_raw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 1'b0;
      sat_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      sat_q   <= sat_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign S    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (8/4, 8/8, 16/4) against a signed-arithmetic
// reference model, plus directed back-to-back, start-ignore and reset-abort sequences.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic [15:0] a_in, b_in;
  logic        ctrl_in, sat_in;

  logic       busy0, done0, cout0, ovf0, zero0;
  logic [7:0] s0;
  logic       busy1, done1, cout1, ovf1, zero1;
  logic [7:0] s1;
  logic        busy2, done2, cout2, ovf2, zero2;
  logic [15:0] s2;

  serial_addsub #(.WIDTH(8), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a_in[7:0]), .B(b_in[7:0]),
    .ctrl(ctrl_in), .sat(sat_in), .busy(busy0), .done(done0), .S(s0),
    .cout(cout0), .ovf(ovf0), .zero(zero0)
  );

  serial_addsub #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a_in[7:0]), .B(b_in[7:0]),
    .ctrl(ctrl_in), .sat(sat_in), .busy(busy1), .done(done1), .S(s1),
    .cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  serial_addsub #(.WIDTH(16), .CHUNK(4)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a_in), .B(b_in),
    .ctrl(ctrl_in), .sat(sat_in), .busy(busy2), .done(done2), .S(s2),
    .cout(cout2), .ovf(ovf2), .zero(zero2)
  );

  always #5 clk = ~clk;

  logic        busy_a[3], done_a[3], cout_a[3], ovf_a[3], zero_a[3];
  logic [15:0] s_a[3];

  always_comb begin
    busy_a[0] = busy0; done_a[0] = done0; cout_a[0] = cout0; ovf_a[0] = ovf0;
    zero_a[0] = zero0; s_a[0] = {8'h00, s0};
    busy_a[1] = busy1; done_a[1] = done1; cout_a[1] = cout1; ovf_a[1] = ovf1;
    zero_a[1] = zero1; s_a[1] = {8'h00, s1};
    busy_a[2] = busy2; done_a[2] = done2; cout_a[2] = cout2; ovf_a[2] = ovf2;
    zero_a[2] = zero2; s_a[2] = s2;
  end

  int          w_of[3] = '{8, 8, 16};
  int          lat[3]  = '{2, 1, 4};
  logic [15:0] e_s[3];
  logic        e_c[3], e_o[3], e_z[3];
  logic [15:0] got_s[3];
  logic        got_c[3], got_o[3], got_z[3];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: interpret operands as signed integers and do ordinary arithmetic.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic c, input logic s, output logic [15:0] rs,
                                output logic rc, output logic ro, output logic rz);
    longint p, ua, ub, sa, sb, r, mx, mn, v;
    p  = longint'(1) << w;
    ua = longint'(a) & (p - 1);
    ub = longint'(b) & (p - 1);
    sa = (ua >= p / 2) ? ua - p : ua;
    sb = (ub >= p / 2) ? ub - p : ub;
    r  = c ? sa - sb : sa + sb;
    mx = p / 2 - 1;
    mn = -(p / 2);
    ro = (r > mx) || (r < mn);
    rc = c ? (ua >= ub) : (ua + ub >= p);
    v  = (s && ro) ? ((r > mx) ? mx : mn) : r;
    rs = 16'(v & (p - 1));
    rz = (rs == 16'h0);
  endfunction

  task automatic observe(input int c, input logic [2:0] act);
    for (int i = 0; i < 3; i++) begin
      if (act[i]) begin
        check($sformatf("d%0d_busy_c%0d", i, c), 16'(busy_a[i]), 16'(c < lat[i]));
        check($sformatf("d%0d_done_c%0d", i, c), 16'(done_a[i]), 16'(c == lat[i]));
        if (c == lat[i]) begin
          got_s[i] = s_a[i]; got_c[i] = cout_a[i]; got_o[i] = ovf_a[i]; got_z[i] = zero_a[i];
          check($sformatf("d%0d_S", i), s_a[i], e_s[i]);
          check($sformatf("d%0d_cout", i), 16'(cout_a[i]), 16'(e_c[i]));
          check($sformatf("d%0d_ovf", i), 16'(ovf_a[i]), 16'(e_o[i]));
          check($sformatf("d%0d_zero", i), 16'(zero_a[i]), 16'(e_z[i]));
        end
      end
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic s, input logic [2:0] act);
    for (int i = 0; i < 3; i++) begin
      model(w_of[i], a, b, c, s, e_s[i], e_c[i], e_o[i], e_z[i]);
    end
    @(negedge clk);
    a_in = a; b_in = b; ctrl_in = c; sat_in = s; start_v = act;
    @(posedge clk); #1;
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (act[i]) begin
        check($sformatf("d%0d_acc_busy", i), 16'(busy_a[i]), 16'h1);
        check($sformatf("d%0d_acc_flags", i), {13'h0, cout_a[i], ovf_a[i], zero_a[i]}, 16'h0);
      end
    end
    // Inputs are scrambled while busy; the captured operands must be used.
    @(negedge clk);
    a_in = 16'($urandom); b_in = 16'($urandom);
    ctrl_in = 1'($urandom); sat_in = 1'($urandom);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      observe(k, act);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start_v = 3'b000; a_in = 16'h0; b_in = 16'h0; ctrl_in = 1'b0; sat_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d_rst_ctl", i), {14'h0, busy_a[i], done_a[i]}, 16'h0);
      check($sformatf("d%0d_rst_S", i), s_a[i], 16'h0);
      check($sformatf("d%0d_rst_flags", i), {13'h0, cout_a[i], ovf_a[i], zero_a[i]}, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, also pinned to literal expectations on the 8/4 instance.
    run_op(16'h05, 16'h03, 1'b0, 1'b0, 3'b111);
    check("add_S", got_s[0], 16'h08);
    check("add_flags", {13'h0, got_c[0], got_o[0], got_z[0]}, 16'h0);
    check("c8_S", got_s[1], 16'h08);
    run_op(16'h05, 16'h05, 1'b1, 1'b0, 3'b111);
    check("sub_eq_S", got_s[0], 16'h00);
    check("sub_eq_flags", {13'h0, got_c[0], got_o[0], got_z[0]}, 16'h5);
    run_op(16'h03, 16'h06, 1'b1, 1'b0, 3'b111);
    check("sub_neg_S", got_s[0], 16'hFD);
    check("sub_neg_flags", {13'h0, got_c[0], got_o[0], got_z[0]}, 16'h0);
    run_op(16'h7F, 16'h01, 1'b0, 1'b0, 3'b111);
    check("wrap_S", got_s[0], 16'h80);
    check("wrap_ovf", 16'(got_o[0]), 16'h1);
    run_op(16'h7F, 16'h01, 1'b0, 1'b1, 3'b111);
    check("satmax_S", got_s[0], 16'h7F);
    check("satmax_ovf", 16'(got_o[0]), 16'h1);
    run_op(16'h80, 16'h01, 1'b1, 1'b1, 3'b111);
    check("satmin_S", got_s[0], 16'h80);
    check("satmin_flags", {13'h0, got_c[0], got_o[0], got_z[0]}, 16'h6);
    run_op(16'h7FFF, 16'h8000, 1'b1, 1'b1, 3'b111);

    // Start during BUSY is ignored on the 8/4 instance.
    @(negedge clk);
    a_in = 16'h05; b_in = 16'h03; ctrl_in = 1'b0; sat_in = 1'b0; start_v = 3'b001;
    @(posedge clk); #1;
    @(negedge clk);
    a_in = 16'h11; b_in = 16'h22; ctrl_in = 1'b1;
    @(posedge clk); #1;
    check("ign_busy", 16'(busy0), 16'h1);
    @(negedge clk);
    start_v = 3'b000;
    @(posedge clk); #1;
    check("ign_done", 16'(done0), 16'h1);
    check("ign_S", 16'(s0), 16'h08);
    @(posedge clk); #1;
    check("ign_idle", {14'h0, busy0, done0}, 16'h0);

    // start held high: accepts back-to-back, done every 3 cycles.
    @(negedge clk);
    a_in = 16'h05; b_in = 16'h03; ctrl_in = 1'b0; sat_in = 1'b0; start_v = 3'b001;
    @(posedge clk); #1;
    @(negedge clk);
    a_in = 16'h7F; b_in = 16'h01; ctrl_in = 1'b0; sat_in = 1'b1;
    @(posedge clk); #1;
    check("b2b_e1_done", 16'(done0), 16'h0);
    @(posedge clk); #1;
    check("b2b_e2_done", 16'(done0), 16'h1);
    check("b2b_e2_S", 16'(s0), 16'h08);
    @(posedge clk); #1;
    check("b2b_e3_ctl", {14'h0, busy0, done0}, 16'h2);
    check("b2b_e3_flags", {13'h0, cout0, ovf0, zero0}, 16'h0);
    @(posedge clk); #1;
    check("b2b_e4_done", 16'(done0), 16'h0);
    @(posedge clk); #1;
    check("b2b_e5_done", 16'(done0), 16'h1);
    check("b2b_e5_S", 16'(s0), 16'h7F);
    check("b2b_e5_ovf", 16'(ovf0), 16'h1);
    @(negedge clk);
    start_v = 3'b000;
    @(posedge clk); #1;
    check("b2b_e6_ctl", {14'h0, busy0, done0}, 16'h0);

    // Reset on the cycle after accept aborts with no done.
    @(negedge clk);
    a_in = 16'h05; b_in = 16'h03; ctrl_in = 1'b0; sat_in = 1'b0; start_v = 3'b001;
    @(posedge clk); #1;
    @(negedge clk);
    start_v = 3'b000; rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ctl", {14'h0, busy0, done0}, 16'h0);
    check("abort_S", 16'(s0), 16'h0);
    check("abort_flags", {13'h0, cout0, ovf0, zero0}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort_nodone_%0d", k), 16'(done0), 16'h0);
    end
    run_op(16'h05, 16'h03, 1'b0, 1'b0, 3'b111);
    check("post_abort_S", got_s[0], 16'h08);

    // Randomized operations against the model.
    repeat (40) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 3'b111);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
